// File: rtl/regfile.sv
// Three-port register file: two combinational read ports, one write port per clock.
// Register 0 reads as zero; addressing it on the write port is the no-write encoding.
module regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] ra1,
    input  logic [ADDR_WIDTH-1:0] ra2,
    input  logic [ADDR_WIDTH-1:0] wa3,
    input  logic [DATA_WIDTH-1:0] wd3,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];

    // Entry 0 is held at zero so no write can ever land there.
    always_comb begin
        regs_d = regs_q;
        if (wa3 != '0) begin
            regs_d[wa3] = wd3;
        end
        regs_d[0] = '0;
    end

    // Reset wins over a write presented on the same edge.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
                regs_q[i] <= '0;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // The zero guard keeps address 0 defined even before the first reset.
    assign rd1 = (ra1 == '0) ? '0 : regs_q[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs_q[ra2];

endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: directed cases plus random traffic, checked by a queue-based
// scoreboard against an array model of the register contents.
module tb_regfile;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int N  = 1 << AW;

    logic          clk;
    logic          reset;
    logic [AW-1:0] ra1, ra2, wa3;
    logic [W-1:0]  wd3;
    logic [W-1:0]  rd1, rd2;

    regfile #(.DATA_WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .ra1   (ra1),
        .ra2   (ra2),
        .wa3   (wa3),
        .wd3   (wd3),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [W-1:0] model_mem [N];

    function automatic logic [W-1:0] model_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        return model_mem[a];
    endfunction

    // ---------------- scoreboard ----------------
    logic [2*W-1:0]  exp_q[$];
    logic [2*AW-1:0] addr_q[$];
    logic            sample_req;
    int              n_checks;
    int              n_fail;

    // Monitor: on the falling edge, compare the read ports with the oldest expectation.
    always @(negedge clk) begin
        if (sample_req) begin
            logic [2*W-1:0]  e;
            logic [2*AW-1:0] a;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_pair: sample with empty queue, got rd1=%08h rd2=%08h", rd1, rd2);
            end else begin
                e = exp_q.pop_front();
                a = addr_q.pop_front();
                if ({rd1, rd2} !== e) begin
                    n_fail++;
                    $display("FAIL rd_pair ra1=%0d ra2=%0d: got rd1=%08h rd2=%08h, expected rd1=%08h rd2=%08h",
                             a[2*AW-1:AW], a[AW-1:0], rd1, rd2, e[2*W-1:W], e[W-1:0]);
                end
            end
        end
    end

    // ---------------- driver ----------------
    // One clock cycle: present inputs, optionally queue the expected reads for
    // this cycle (pre-edge contents), then apply the edge's effect to the model.
    task automatic cycle(input logic rst, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                         input logic [AW-1:0] a1, input logic [AW-1:0] a2, input bit chk);
        reset = rst;
        wa3   = wa;
        wd3   = wd;
        ra1   = a1;
        ra2   = a2;
        sample_req = chk;
        if (chk) begin
            exp_q.push_back({model_read(a1), model_read(a2)});
            addr_q.push_back({a1, a2});
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < N; i++) model_mem[i] = '0;
        end else if (wa != 0) begin
            model_mem[wa] = wd;
        end
        #1;
        sample_req = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        cycle(1'b0, '0, $urandom, a1, a2, 1'b1);
    endtask

    task automatic wr(input logic [AW-1:0] wa, input logic [W-1:0] wd);
        cycle(1'b0, wa, wd, $urandom_range(0, N-1), $urandom_range(0, N-1), 1'b0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int pairs [5][2];
        n_checks   = 0;
        n_fail     = 0;
        sample_req = 1'b0;
        reset = 1'b1; wa3 = '0; wd3 = '0; ra1 = '0; ra2 = '0;
        for (int i = 0; i < N; i++) model_mem[i] = 'x;
        @(posedge clk); #1;

        // Reset held for two edges; contents are defined after the first.
        cycle(1'b1, '0, '0, '0, '0, 1'b0);
        cycle(1'b1, '0, '0, 5'd7, 5'd0, 1'b1);

        pairs = '{'{0, 0}, '{2, 1}, '{5, 4}, '{13, 2}, '{3, 8}};
        foreach (pairs[i]) rd(pairs[i][0], pairs[i][1]);

        // Write then read back.
        wr(5, 32'hDEADBEEF);
        rd(5, 5);
        wr(13, 32'h12345678);
        rd(13, 5);

        // Register 0 immunity: read during the attempted write and after it.
        cycle(1'b0, '0, 32'hFFFFFFFF, '0, 5, 1'b1);
        rd(0, 0);

        // Read-during-write: old value before the edge, new value after.
        wr(4, 32'h11);
        cycle(1'b0, 4, 32'h22, 4, 4, 1'b1);
        rd(4, 0);

        // Reset beats a simultaneous write and wipes earlier data.
        wr(3, 32'hA5A5A5A5);
        cycle(1'b1, 3, 32'h5A5A5A5A, 3, 5, 1'b1);
        rd(3, 5);
        rd(13, 4);

        // Full sweep.
        for (int i = 1; i < N; i++) wr(i[AW-1:0], i * 32'h01010101);
        for (int i = 0; i < N; i++) rd(i[AW-1:0], 5'(N - 1 - i));

        // Random traffic with occasional reset; every cycle is checked.
        for (int k = 0; k < 400; k++) begin
            logic          r;
            logic [AW-1:0] wa;
            r  = ($urandom_range(0, 49) == 0);
            wa = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom_range(0, N-1));
            cycle(r, wa, $urandom, AW'($urandom_range(0, N-1)), AW'($urandom_range(0, N-1)), 1'b1);
        end

        @(posedge clk); #1;
        @(negedge clk); #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending entries, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
